// File: rtl/divider_4bit_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : divider_4bit_seq_pkg
//  Description : Shared types for the sequential restoring divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package divider_4bit_seq_pkg;

  localparam int DIV_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/div_trial_sub.sv
`default_nettype none
// ============================================================================
//  Module      : div_trial_sub
//  Description : (N+1)-bit trial subtractor {0,a}-{0,b}; ripple of full adders.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_trial_sub #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N:0] w_c;

  assign w_c[0] = 1'b1;

  // a + ~b + 1, one full-adder cell per bit
  for (genvar i = 0; i < N; i++) begin : g_fa
    logic w_y;
    assign w_y       = ~b[i];
    assign diff[i]   = a[i] ^ w_y ^ w_c[i];
    assign w_c[i+1]  = (a[i] & w_y) | (w_c[i] & (a[i] ^ w_y));
  end

  // Top cell sees a=0, ~b=1: its sum bit is the sign of the trial result
  assign borrow = 1'b0 ^ 1'b1 ^ w_c[N];

endmodule
`default_nettype wire

// File: rtl/divider_4bit_seq.sv
`default_nettype none
// ============================================================================
//  Module      : divider_4bit_seq
//  Description : Sequential restoring divider, one quotient bit per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module divider_4bit_seq
  import divider_4bit_seq_pkg::*;
#(
  parameter int N = DIV_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CNT_W = $clog2(N + 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0]     r_r;
  logic [N-1:0]     r_q;
  logic [N-1:0]     r_d;
  logic [N-1:0]     w_r_shift;
  logic [N-1:0]     w_q_next;
  logic [N-1:0]     w_r_next;
  logic [N-1:0]     w_diff;
  logic             w_borrow;
  logic             w_unused;

  // R is always below 2^k after k steps, so its MSB never shifts out
  assign w_unused  = r_r[N-1];
  assign w_r_shift = {r_r[N-2:0], r_q[N-1]};
  assign w_q_next  = {r_q[N-2:0], ~w_borrow};
  assign w_r_next  = w_borrow ? w_r_shift : w_diff;

  div_trial_sub #(.N(N)) u_trial (
    .a      (w_r_shift),
    .b      (r_d),
    .diff   (w_diff),
    .borrow (w_borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = (divisor == '0) ? DONE : RUN;
      RUN:     if (r_cnt == CNT_W'(1)) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_r         <= '0;
      r_q         <= '0;
      r_d         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_d   <= divisor;
            r_q   <= dividend;
            r_r   <= '0;
            r_cnt <= CNT_W'(N);
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          r_r   <= w_r_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            quotient  <= w_q_next;
            remainder <= w_r_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_divider_4bit_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divider_4bit_seq
//  Description : Self-checking bench for divider_4bit_seq against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_4bit_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  divider_4bit_seq #(.N(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Reference: plain unsigned division, all-ones quotient on zero divisor
  function automatic logic [8:0] model(input logic [3:0] a, input logic [3:0] b);
    if (b == 4'd0) return {1'b1, 4'hF, a};
    return {1'b0, 4'(a / b), 4'(a % b)};
  endfunction

  // Issue one request; report done latency (0 = timeout), busy count, overlap, results
  task automatic run_div(input logic [3:0] a, input logic [3:0] b, input bit scramble,
                         output int lat, output int nbusy, output bit overlap,
                         output logic [3:0] q, output logic [3:0] r, output logic z);
    lat = 0; nbusy = 0; overlap = 1'b0; q = 'x; r = 'x; z = 1'bx;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (busy && done) overlap = 1'b1;
      if (scramble) {dividend, divisor} = 8'($urandom);
      if (done) begin
        lat = i; q = quotient; r = remainder; z = div_by_zero;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #3;
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0)        begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (quotient !== 4'd0)    begin errors++; $display("FAIL reset_q got %0h want 0", quotient); end
    checks++; if (remainder !== 4'd0)   begin errors++; $display("FAIL reset_r got %0h want 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %0b want 0", div_by_zero); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [3:0] av [4] = '{4'd13, 4'd15, 4'd7, 4'd0};
    logic [3:0] bv [4] = '{4'd4, 4'd1, 4'd9, 4'd5};
    int lat, nb; bit ov; logic [3:0] q, r; logic z; logic [8:0] exp;
    for (int k = 0; k < 4; k++) begin
      run_div(av[k], bv[k], 1'b0, lat, nb, ov, q, r, z);
      exp = model(av[k], bv[k]);
      checks++; if (lat != 5) begin errors++; $display("FAIL basic_latency %0d/%0d got %0d want 5", av[k], bv[k], lat); end
      checks++; if (nb != 4)  begin errors++; $display("FAIL basic_busy %0d/%0d got %0d want 4", av[k], bv[k], nb); end
      checks++; if ({z, q, r} !== exp) begin errors++; $display("FAIL basic_result %0d/%0d got z%0b q%0d r%0d want %h", av[k], bv[k], z, q, r, exp); end
    end
    // Results hold and done drops after the pulse
    @(negedge clk);
    checks++; if (done !== 1'b0 || quotient !== 4'd0 || remainder !== 4'd0) begin
      errors++; $display("FAIL basic_hold got done%0b q%0d r%0d want 0 0 0", done, quotient, remainder); end
  endtask

  task automatic test_div_by_zero;
    int lat, nb; bit ov; logic [3:0] q, r; logic z;
    run_div(4'd9, 4'd0, 1'b0, lat, nb, ov, q, r, z);
    checks++; if (lat != 1) begin errors++; $display("FAIL dbz_latency got %0d want 1", lat); end
    checks++; if (nb != 0)  begin errors++; $display("FAIL dbz_busy got %0d want 0", nb); end
    checks++; if ({z, q, r} !== {1'b1, 4'hF, 4'd9}) begin errors++; $display("FAIL dbz_result got z%0b q%0h r%0d want 1 F 9", z, q, r); end
    run_div(4'd8, 4'd2, 1'b0, lat, nb, ov, q, r, z);
    checks++; if (lat != 5 || {z, q, r} !== {1'b0, 4'd4, 4'd0}) begin
      errors++; $display("FAIL dbz_after lat%0d got z%0b q%0d r%0d want 5 0 4 0", lat, z, q, r); end
  endtask

  task automatic test_start_held;
    int dones = 0; int lat = 0;
    logic [3:0] q = 'x, r = 'x;
    @(negedge clk);
    dividend = 4'd11; divisor = 4'd2; start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (done) begin dones++; lat = i; q = quotient; r = remainder; end
      else {dividend, divisor} = 8'($urandom);
    end
    checks++; if (lat != 5 || q !== 4'd5 || r !== 4'd1) begin
      errors++; $display("FAIL held_result lat%0d got q%0d r%0d want 5 5 1", lat, q, r); end
    dividend = 4'd6; divisor = 4'd3;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL held_idle got busy%0b done%0b want 0 0", busy, done); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL held_reaccept got busy%0b want 1", busy); end
    start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (done) begin lat = i; q = quotient; r = remainder; end
    end
    checks++; if (lat != 4 || q !== 4'd2 || r !== 4'd0) begin
      errors++; $display("FAIL held_second lat%0d got q%0d r%0d want 4 2 0", lat, q, r); end
  endtask

  task automatic test_reset_mid;
    int lat, nb; bit ov; logic [3:0] q, r; logic z; bit seen = 1'b0;
    run_div(4'd13, 4'd4, 1'b0, lat, nb, ov, q, r, z);
    @(negedge clk);
    dividend = 4'd14; divisor = 4'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, quotient, remainder, div_by_zero} !== 11'd0) begin
      errors++; $display("FAIL midreset_clear got b%0b d%0b q%0d r%0d z%0b want all 0", busy, done, quotient, remainder, div_by_zero); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midreset_nodone got 1 want 0"); end
    run_div(4'd14, 4'd3, 1'b0, lat, nb, ov, q, r, z);
    checks++; if (lat != 5 || {z, q, r} !== {1'b0, 4'd4, 4'd2}) begin
      errors++; $display("FAIL midreset_after lat%0d got z%0b q%0d r%0d want 5 0 4 2", lat, z, q, r); end
  endtask

  task automatic test_exhaustive;
    int lat, nb; bit ov; logic [3:0] q, r; logic z;
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_div(4'(a), 4'(b), 1'b1, lat, nb, ov, q, r, z);
        checks++;
        if (lat != 5 || nb != 4 || ov || z !== 1'b0 ||
            (int'(q) * b + int'(r)) != a || int'(r) >= b) begin
          errors++;
          $display("FAIL exhaustive %0d/%0d got lat%0d busy%0d ov%0b z%0b q%0d r%0d", a, b, lat, nb, ov, z, q, r);
        end
      end
    end
  endtask

  task automatic test_random;
    int lat, nb; bit ov; logic [3:0] q, r; logic z; logic [3:0] a, b; logic [8:0] exp;
    for (int k = 0; k < 40; k++) begin
      a = 4'($urandom); b = (k % 5 == 0) ? 4'd0 : 4'($urandom);
      run_div(a, b, 1'b1, lat, nb, ov, q, r, z);
      exp = model(a, b);
      checks++;
      if (lat != ((b == 0) ? 1 : 5) || ov || {z, q, r} !== exp) begin
        errors++; $display("FAIL random %0d/%0d got lat%0d ov%0b z%0b q%0d r%0d want %h", a, b, lat, ov, z, q, r, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_by_zero();
    test_start_held();
    test_reset_mid();
    test_exhaustive();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
